// File: rtl/uart_text_writer.sv
// Turns received UART bytes into text-memory writes, tracking a cursor over a COLS x ROWS grid
// and handling CR/LF/BS/FF plus a hardware clear-screen sweep.
module uart_text_writer #(
    parameter int unsigned COLS           = 100,
    parameter int unsigned ROWS           = 75,
    parameter int unsigned ADDR_W         = 13,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic [ADDR_W-1:0] address,
    output logic [7:0]        data,
    output logic              write,
    output logic              busy,
    output logic              dropped,
    output logic [6:0]        cursor_col,
    output logic [6:0]        cursor_row
);

    localparam logic [6:0]        LastCol  = 7'(COLS - 1);
    localparam logic [6:0]        LastRow  = 7'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ColsA    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] OneA     = ADDR_W'(1);

    typedef enum logic [1:0] {StIdle, StWrite, StClear} state_e;

    state_e            state_q, state_d;
    logic [6:0]        col_q, col_d, row_q, row_d;
    logic [ADDR_W-1:0] caddr_q, caddr_d;
    logic [ADDR_W-1:0] clr_q, clr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              write_q, write_d;
    logic              dropped_q, dropped_d;
    logic              init_q, init_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            col_q     <= '0;
            row_q     <= '0;
            caddr_q   <= '0;
            clr_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            write_q   <= 1'b0;
            dropped_q <= 1'b0;
            init_q    <= CLEAR_ON_RESET;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            caddr_q   <= caddr_d;
            clr_q     <= clr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            write_q   <= write_d;
            dropped_q <= dropped_d;
            init_q    <= init_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        caddr_d   = caddr_q;
        clr_d     = clr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        write_d   = 1'b0;
        dropped_d = 1'b0;
        init_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (init_q) begin
                    // Post-reset sweep takes priority over any byte arriving on the first clock.
                    state_d   = StClear;
                    clr_d     = '0;
                    addr_d    = '0;
                    data_d    = 8'h20;
                    write_d   = 1'b1;
                    dropped_d = rx_ready;
                end else if (rx_ready) begin
                    if (rx_data >= 8'h20 && rx_data <= 8'h7E) begin
                        write_d = 1'b1;
                        data_d  = rx_data;
                        addr_d  = caddr_q;
                        state_d = StWrite;
                        if (col_q == LastCol) begin
                            col_d = '0;
                            if (row_q == LastRow) begin
                                row_d   = '0;
                                caddr_d = '0;
                            end else begin
                                row_d   = row_q + 7'd1;
                                caddr_d = caddr_q + OneA;
                            end
                        end else begin
                            col_d   = col_q + 7'd1;
                            caddr_d = caddr_q + OneA;
                        end
                    end else begin
                        case (rx_data)
                            8'h0D: begin
                                col_d   = '0;
                                caddr_d = caddr_q - ADDR_W'(col_q);
                            end
                            8'h0A: begin
                                col_d = '0;
                                if (row_q == LastRow) begin
                                    row_d   = '0;
                                    caddr_d = '0;
                                end else begin
                                    row_d   = row_q + 7'd1;
                                    caddr_d = caddr_q - ADDR_W'(col_q) + ColsA;
                                end
                            end
                            8'h08: begin
                                // Stepping back one cell is always linear address - 1, even across rows.
                                if (col_q != '0 || row_q != '0) begin
                                    if (col_q != '0) begin
                                        col_d = col_q - 7'd1;
                                    end else begin
                                        col_d = LastCol;
                                        row_d = row_q - 7'd1;
                                    end
                                    caddr_d = caddr_q - OneA;
                                    addr_d  = caddr_q - OneA;
                                    data_d  = 8'h20;
                                    write_d = 1'b1;
                                    state_d = StWrite;
                                end
                            end
                            8'h0C: begin
                                state_d = StClear;
                                clr_d   = '0;
                                addr_d  = '0;
                                data_d  = 8'h20;
                                write_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            StWrite: begin
                state_d   = StIdle;
                dropped_d = rx_ready;
            end
            StClear: begin
                dropped_d = rx_ready;
                if (clr_q == LastAddr) begin
                    state_d = StIdle;
                    col_d   = '0;
                    row_d   = '0;
                    caddr_d = '0;
                end else begin
                    clr_d   = clr_q + OneA;
                    addr_d  = clr_q + OneA;
                    data_d  = 8'h20;
                    write_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign address    = addr_q;
    assign data       = data_q;
    assign write      = write_q;
    assign dropped    = dropped_q;
    assign busy       = (state_q != StIdle);
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_uart_text_writer.sv
// Randomized self-checking bench for uart_text_writer against a cursor/screen reference model.
`timescale 1ns/1ps
module tb_uart_text_writer;

    localparam int COLS = 100;
    localparam int ROWS = 75;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready = 1'b0;
    logic [12:0] address;
    logic [7:0]  data;
    logic        write, busy, dropped;
    logic [6:0]  cursor_col, cursor_row;

    int checks = 0;
    int errors = 0;
    int m_col = 0;
    int m_row = 0;

    uart_text_writer #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_W(13), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
        .address(address), .data(data), .write(write), .busy(busy), .dropped(dropped),
        .cursor_col(cursor_col), .cursor_row(cursor_row)
    );

    always #12.5 clock = ~clock;

    // Model: screen position as a linear cell index; returns the expected memory write.
    task automatic model_byte(input logic [7:0] b, output bit ew, output int ea, output int ed);
        int pos;
        ew = 0; ea = 0; ed = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            ew = 1; ea = m_row * COLS + m_col; ed = int'(b);
            pos = (ea + 1) % (COLS * ROWS);
            m_col = pos % COLS; m_row = pos / COLS;
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_col = 0; m_row = (m_row + 1) % ROWS;
        end else if (b == 8'h08 && (m_col > 0 || m_row > 0)) begin
            pos = m_row * COLS + m_col - 1;
            ew = 1; ea = pos; ed = 32'h20;
            m_col = pos % COLS; m_row = pos / COLS;
        end
    endtask

    task automatic apply_byte(input logic [7:0] b);
        bit ew; int ea; int ed;
        model_byte(b, ew, ea, ed);
        @(negedge clock); rx_data = b; rx_ready = 1'b1;
        @(negedge clock); rx_ready = 1'b0;
        checks++;
        if (write !== ew || (ew && (address !== 13'(ea) || data !== 8'(ed)))) begin
            errors++;
            $display("FAIL byte_write b=%02h: got w=%0b a=%0d d=%02h, want w=%0b a=%0d d=%02h",
                     b, write, address, data, ew, ea, ed);
        end
        checks++;
        if (cursor_col !== 7'(m_col) || cursor_row !== 7'(m_row) || dropped !== 1'b0) begin
            errors++;
            $display("FAIL byte_cursor b=%02h: got (%0d,%0d) drop=%0b, want (%0d,%0d) drop=0",
                     b, cursor_col, cursor_row, dropped, m_col, m_row);
        end
        @(negedge clock);
        checks++;
        if (write !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL byte_settle b=%02h: got w=%0b busy=%0b, want 0 0", b, write, busy);
        end
    endtask

    task automatic goto_cursor(input int c, input int r);
        apply_byte(8'h0D);
        while (m_row != r) apply_byte(8'h0A);
        repeat (c) apply_byte(8'h2E);
    endtask

    // Checks a full sweep starting at the next negedge; optionally injects bytes mid-sweep.
    task automatic expect_sweep(input bit inject);
        int bad = 0; int bad_k = -1;
        for (int k = 0; k < COLS * ROWS; k++) begin
            @(negedge clock);
            if (write !== 1'b1 || address !== 13'(k) || data !== 8'h20 || busy !== 1'b1) begin
                if (bad == 0) bad_k = k;
                bad++;
            end
            if (inject) begin
                if (k == 100) begin rx_data = 8'h51; rx_ready = 1'b1; end
                if (k == 150) begin rx_data = 8'h0C; rx_ready = 1'b1; end
                if (k == 101 || k == 151) begin
                    rx_ready = 1'b0;
                    checks++;
                    if (dropped !== 1'b1) begin
                        errors++;
                        $display("FAIL clear_dropped k=%0d: got %0b, want 1", k, dropped);
                    end
                end
                if (k == 102 || k == 152) begin
                    checks++;
                    if (dropped !== 1'b0) begin
                        errors++;
                        $display("FAIL clear_dropped_width k=%0d: got %0b, want 0", k, dropped);
                    end
                end
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL clear_sweep: %0d bad cycles, first at index %0d, want 0", bad, bad_k);
        end
        @(negedge clock);
        m_col = 0; m_row = 0;
        checks++;
        if (write !== 1'b0 || busy !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 7'd0) begin
            errors++;
            $display("FAIL clear_end: got w=%0b busy=%0b cur=(%0d,%0d), want 0 0 (0,0)",
                     write, busy, cursor_col, cursor_row);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        checks++;
        if ({write, busy, dropped, address, data, cursor_col, cursor_row} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got w=%0b b=%0b d=%0b a=%0d data=%02h cur=(%0d,%0d), want 0",
                     write, busy, dropped, address, data, cursor_col, cursor_row);
        end
    endtask

    task automatic test_initial_clear;
        reset = 1'b1;
        expect_sweep(1'b0);
    endtask

    task automatic test_printable;
        apply_byte(8'h41);
        apply_byte(8'h42);
        checks++;
        if (cursor_col !== 7'd2) begin
            errors++;
            $display("FAIL ab_cursor: got %0d, want 2", cursor_col);
        end
    endtask

    task automatic test_wrap;
        goto_cursor(99, 74);
        apply_byte(8'h5A);
        goto_cursor(99, 3);
        apply_byte(8'h78);
        apply_byte(8'h79);
    endtask

    task automatic test_controls;
        goto_cursor(5, 2);
        apply_byte(8'h0D);
        apply_byte(8'h0A);
        apply_byte(8'h08);
        goto_cursor(0, 0);
        apply_byte(8'h08);
        apply_byte(8'h08);
    endtask

    task automatic test_random;
        logic [7:0] b;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: b = 8'($urandom_range(32, 126));
                4: b = 8'h0D;
                5: b = 8'h0A;
                6, 7: b = 8'h08;
                8: b = 8'($urandom_range(128, 255));
                default: b = 8'($urandom_range(0, 7));
            endcase
            apply_byte(b);
        end
    endtask

    task automatic test_back_to_back;
        bit ew; int ea; int ed;
        model_byte(8'h4D, ew, ea, ed);
        @(negedge clock); rx_data = 8'h4D; rx_ready = 1'b1;
        @(negedge clock); rx_data = 8'h4E;
        checks++;
        if (write !== 1'b1 || address !== 13'(ea) || data !== 8'h4D) begin
            errors++;
            $display("FAIL b2b_first: got w=%0b a=%0d d=%02h, want 1 %0d 4d", write, address, data, ea);
        end
        @(negedge clock); rx_ready = 1'b0;
        checks++;
        if (dropped !== 1'b1 || write !== 1'b0 || cursor_col !== 7'(m_col) || cursor_row !== 7'(m_row)) begin
            errors++;
            $display("FAIL b2b_drop: got drop=%0b w=%0b cur=(%0d,%0d), want 1 0 (%0d,%0d)",
                     dropped, write, cursor_col, cursor_row, m_col, m_row);
        end
        @(negedge clock);
        checks++;
        if (dropped !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drop_width: got %0b, want 0", dropped);
        end
    endtask

    task automatic test_ff_clear;
        @(negedge clock); rx_data = 8'h0C; rx_ready = 1'b1;
        @(posedge clock); #1 rx_ready = 1'b0;
        expect_sweep(1'b1);
        apply_byte(8'h41);
    endtask

    task automatic test_reset_mid_clear;
        bit found = 0;
        @(negedge clock); rx_data = 8'h0C; rx_ready = 1'b1;
        @(posedge clock); #1 rx_ready = 1'b0;
        for (int i = 0; i < 8000 && !found; i++) begin
            @(negedge clock);
            if (address == 13'd3000 && write) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midclear_reach: address 3000 not seen, got %0d", address);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (write !== 1'b0 || address !== 13'd0 || busy !== 1'b0 || data !== 8'h00) begin
            errors++;
            $display("FAIL midclear_async: got w=%0b a=%0d busy=%0b d=%02h, want 0 0 0 00",
                     write, address, busy, data);
        end
        m_col = 0; m_row = 0;
        @(negedge clock);
        reset = 1'b1;
        expect_sweep(1'b0);
    endtask

    initial begin
        test_reset();
        test_initial_clear();
        test_printable();
        test_wrap();
        test_controls();
        test_back_to_back();
        test_random();
        test_ff_clear();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
